// File: rtl/pe_line_feeder.sv
// Read-side sequencer feeding the PE array: line-buffer reset, filter words, bias word, then
// input rows. Each buffer read is paired with a shift strobe that fires one cycle later.
module pe_line_feeder #(
    parameter int N_BUF  = 33,
    parameter int N_PE   = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [ADDR_W-1:0] row_length,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [7:0]        filter_len,
    input  logic [N_PE-1:0]   filter_mask,
    input  logic [ADDR_W-1:0] filter_base,
    input  logic              bias_en,
    input  logic [ADDR_W-1:0] bias_addr,
    input  logic [ADDR_W-1:0] line_base,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              line_buffer_reset,
    output logic [N_BUF-1:0]  shifting_line,
    output logic [N_PE-1:0]   shifting_filter,
    output logic              shifting_bias,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, LBRST, FILT, BIAS, BIAS_WAIT, LINE, DRAIN, DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] row_len_q, num_rows_q, filt_base_q, bias_addr_q, line_base_q;
    logic [7:0]        filt_len_q;
    logic [N_PE-1:0]   mask_q;
    logic              bias_en_q;

    logic [7:0]        filt_idx;
    logic [ADDR_W-1:0] col, row, line_off;

    logic              issue;
    logic [ADDR_W-1:0] rd_addr;
    logic              line_empty;
    logic              line_q, bias_q;
    logic [N_PE-1:0]   filt_q;

    assign line_empty = (row_len_q == '0) || (num_rows_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        rd_addr   = '0;
        case (state)
            IDLE: if (start && !abort) state_nxt = LBRST;
            LBRST: begin
                if (filt_len_q != 8'd0) state_nxt = FILT;
                else if (bias_en_q)     state_nxt = BIAS;
                else if (line_empty)    state_nxt = DRAIN;
                else                    state_nxt = LINE;
            end
            FILT: begin
                rd_addr = filt_base_q + ADDR_W'(filt_idx);
                issue   = !stall;
                if (!stall && filt_idx == filt_len_q - 8'd1) begin
                    if (bias_en_q)       state_nxt = BIAS;
                    else if (line_empty) state_nxt = DRAIN;
                    else                 state_nxt = LINE;
                end
            end
            BIAS: begin
                if (!bias_en_q) begin
                    state_nxt = line_empty ? DRAIN : LINE;
                end else begin
                    rd_addr = bias_addr_q;
                    issue   = !stall;
                    if (!stall) state_nxt = BIAS_WAIT;
                end
            end
            BIAS_WAIT: state_nxt = line_empty ? DRAIN : LINE;
            LINE: begin
                rd_addr = line_base_q + line_off;
                issue   = !stall;
                if (!stall && col == row_len_q - 1'b1 && row == num_rows_q - 1'b1)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort cancels the read in flight so its strobe never appears
        if (abort) begin
            issue = 1'b0;
            if (state != IDLE) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_len_q   <= '0;
            num_rows_q  <= '0;
            filt_base_q <= '0;
            bias_addr_q <= '0;
            line_base_q <= '0;
            filt_len_q  <= '0;
            mask_q      <= '0;
            bias_en_q   <= 1'b0;
            filt_idx    <= '0;
            col         <= '0;
            row         <= '0;
            line_off    <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                row_len_q   <= row_length;
                num_rows_q  <= num_rows;
                filt_base_q <= filter_base;
                bias_addr_q <= bias_addr;
                line_base_q <= line_base;
                filt_len_q  <= filter_len;
                mask_q      <= filter_mask;
                bias_en_q   <= bias_en;
            end
            if (state == LBRST) begin
                filt_idx <= '0;
                col      <= '0;
                row      <= '0;
                line_off <= '0;
            end
            if (issue && state == FILT) filt_idx <= filt_idx + 8'd1;
            if (issue && state == LINE) begin
                line_off <= line_off + 1'b1;
                if (col == row_len_q - 1'b1) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Strobe stage: registered copy of the read issued last cycle, tagged by its phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= 1'b0;
            filt_q <= '0;
            bias_q <= 1'b0;
        end else begin
            line_q <= issue && (state == LINE);
            filt_q <= (issue && state == FILT) ? mask_q : '0;
            bias_q <= issue && (state == BIAS);
        end
    end

    assign buf_rd_en         = issue;
    assign buf_rd_addr       = rd_addr;
    assign line_buffer_reset = (state == LBRST);
    assign shifting_line     = {N_BUF{line_q}};
    assign shifting_filter   = filt_q;
    assign shifting_bias     = bias_q;
    assign busy              = (state != IDLE) && (state != DONE);
    assign done              = (state == DONE) && !abort;

endmodule
